// File: rtl/operand_forward_if.sv
// Pipeline-side bundle for operand_forward: EX/MEM/WB qualifiers and register values in,
// forwarded operands, source selects, load-use stall and stall count out.
interface operand_forward_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned XADDR = 5,
    parameter int unsigned NPORT = 2,
    parameter int unsigned CNTW  = 16
);
    localparam int unsigned SELW = 3;

    logic                    i_flush;
    logic                    i_ex_valid;
    logic                    i_ex_accept;
    logic [NPORT-1:0]        i_rs_used;
    logic [NPORT*XADDR-1:0]  i_rs_addr_ex;
    logic [NPORT*XLEN-1:0]   i_rs_ex;

    logic                    i_mem_valid;
    logic                    i_mem_is_load;
    logic                    i_rd_mem_wr_en;
    logic [XADDR-1:0]        i_rd_addr_mem;
    logic [XLEN-1:0]         i_rd_mem;
    logic                    i_mem_req_complete;
    logic [XLEN-1:0]         i_mem_data;

    logic                    i_wb_valid;
    logic                    i_rd_wb_wr_en;
    logic [XADDR-1:0]        i_rd_addr_wb;
    logic [XLEN-1:0]         i_rd_wb;

    logic [NPORT*XLEN-1:0]   o_rs;
    logic [NPORT*SELW-1:0]   o_fwd_sel;
    logic                    o_load_stall;
    logic [CNTW-1:0]         o_stall_count;

    // Pipeline side: drives stage state, consumes operands and stall.
    modport master (
        output i_flush, i_ex_valid, i_ex_accept, i_rs_used, i_rs_addr_ex, i_rs_ex,
               i_mem_valid, i_mem_is_load, i_rd_mem_wr_en, i_rd_addr_mem, i_rd_mem,
               i_mem_req_complete, i_mem_data,
               i_wb_valid, i_rd_wb_wr_en, i_rd_addr_wb, i_rd_wb,
        input  o_rs, o_fwd_sel, o_load_stall, o_stall_count
    );

    // Forwarding unit side.
    modport slave (
        input  i_flush, i_ex_valid, i_ex_accept, i_rs_used, i_rs_addr_ex, i_rs_ex,
               i_mem_valid, i_mem_is_load, i_rd_mem_wr_en, i_rd_addr_mem, i_rd_mem,
               i_mem_req_complete, i_mem_data,
               i_wb_valid, i_rd_wb_wr_en, i_rd_addr_wb, i_rd_wb,
        output o_rs, o_fwd_sel, o_load_stall, o_stall_count
    );
endinterface

// File: rtl/operand_forward.sv
// RV32I EX-stage operand forwarding with load-use interlock, a hold register that keeps
// completed load data visible to a stalled EX instruction, and a saturating stall counter.
module operand_forward #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned XADDR = 5,
    parameter int unsigned NPORT = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    operand_forward_if.slave  bus
);
    localparam int unsigned SELW = 3;

    localparam logic [SELW-1:0] SEL_RF   = SELW'(0);
    localparam logic [SELW-1:0] SEL_MEM  = SELW'(1);
    localparam logic [SELW-1:0] SEL_LOAD = SELW'(2);
    localparam logic [SELW-1:0] SEL_WB   = SELW'(3);
    localparam logic [SELW-1:0] SEL_HOLD = SELW'(4);
    localparam logic [SELW-1:0] SEL_ZERO = SELW'(5);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              hold_valid_q, hold_valid_d;
    logic [XADDR-1:0]  hold_addr_q, hold_addr_d;
    logic [XLEN-1:0]   hold_data_q, hold_data_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              mem_fwd_en_c;
    logic              wb_fwd_en_c;
    logic [NPORT-1:0]  pending_c;
    logic [NPORT-1:0]  load_hit_c;
    logic              load_stall_c;
    logic              load_done_c;
    logic              capture_c;
    logic              clear_hold_c;

    assign mem_fwd_en_c = bus.i_mem_valid & bus.i_rd_mem_wr_en;
    assign wb_fwd_en_c  = bus.i_wb_valid  & bus.i_rd_wb_wr_en;

    // Per-port source selection; MEM is younger than WB, hold is the oldest source.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [XADDR-1:0] addr;
        logic [XLEN-1:0]  rf_val;
        logic [XLEN-1:0]  rs_val;
        logic [SELW-1:0]  sel;
        logic             mem_hit;
        logic             wb_hit;
        logic             hold_hit;
        logic             pend;

        assign addr     = bus.i_rs_addr_ex[p*XADDR +: XADDR];
        assign rf_val   = bus.i_rs_ex[p*XLEN +: XLEN];
        assign mem_hit  = mem_fwd_en_c & (addr == bus.i_rd_addr_mem);
        assign wb_hit   = wb_fwd_en_c  & (addr == bus.i_rd_addr_wb);
        assign hold_hit = hold_valid_q & (addr == hold_addr_q);

        always_comb begin : operand_mux
            rs_val = rf_val;
            sel    = SEL_RF;
            pend   = 1'b0;
            if (addr == '0) begin
                rs_val = '0;
                sel    = SEL_ZERO;
            end else if (mem_hit && bus.i_mem_is_load) begin
                if (bus.i_mem_req_complete) begin
                    rs_val = bus.i_mem_data;
                    sel    = SEL_LOAD;
                end else begin
                    pend   = 1'b1;
                end
            end else if (mem_hit) begin
                rs_val = bus.i_rd_mem;
                sel    = SEL_MEM;
            end else if (wb_hit) begin
                rs_val = bus.i_rd_wb;
                sel    = SEL_WB;
            end else if (hold_hit) begin
                rs_val = hold_data_q;
                sel    = SEL_HOLD;
            end
        end

        assign bus.o_rs[p*XLEN +: XLEN]      = rs_val;
        assign bus.o_fwd_sel[p*SELW +: SELW] = sel;
        assign pending_c[p]                  = pend;
        // A port whose operand is being delivered by a load in MEM this cycle or later.
        assign load_hit_c[p] = bus.i_rs_used[p] & mem_hit & bus.i_mem_is_load & (addr != '0);
    end

    assign load_stall_c = bus.i_ex_valid & (|(bus.i_rs_used & pending_c));
    assign load_done_c  = bus.i_ex_valid & bus.i_mem_req_complete & (|load_hit_c);

    assign bus.o_load_stall  = load_stall_c;
    assign bus.o_stall_count = cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (bus.i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_done_c && !bus.i_ex_accept) begin
                        state_d = ST_HOLD;
                    end else if (load_stall_c) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (load_done_c && !bus.i_ex_accept) begin
                        state_d = ST_HOLD;
                    end else if (!load_stall_c) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_ex_accept) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Hold capture/clear strobes; flush wins over a capture in the same cycle.
    always_comb begin : fsm_out
        capture_c    = 1'b0;
        clear_hold_c = 1'b0;
        if (bus.i_flush) begin
            clear_hold_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    capture_c = load_done_c & ~bus.i_ex_accept;
                end
                ST_HOLD: begin
                    if (bus.i_ex_accept) begin
                        clear_hold_c = 1'b1;
                    end else begin
                        capture_c = load_done_c;
                    end
                end
                default: clear_hold_c = 1'b1;
            endcase
        end
    end

    always_comb begin : hold_next
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        if (clear_hold_c) begin
            hold_valid_d = 1'b0;
        end else if (capture_c) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = bus.i_rd_addr_mem;
            hold_data_d  = bus.i_mem_data;
        end
    end

    // Saturating load-use stall counter; survives flush.
    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (load_stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : data_reg
        if (!i_rst_n) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_operand_forward.sv
// Self-checking bench for operand_forward: table of single-cycle forwarding vectors plus
// hand-written load-use, hold, flush, async-reset and counter-saturation sequences.
module tb_operand_forward;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned XADDR = 5;
    localparam int unsigned NPORT = 2;
    localparam int unsigned CNTW  = 4;
    localparam logic [CNTW-1:0] CNT_MAX = 4'hF;
    localparam logic [31:0] RS0 = 32'h0000_0500;
    localparam logic [31:0] RS1 = 32'h0000_0300;

    logic clk;
    logic rst_n;

    operand_forward_if #(.XLEN(XLEN), .XADDR(XADDR), .NPORT(NPORT), .CNTW(CNTW)) bus ();

    operand_forward #(.XLEN(XLEN), .XADDR(XADDR), .NPORT(NPORT), .CNTW(CNTW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ex_valid;
        logic [1:0]  used;
        logic [4:0]  a0, a1;
        logic        mv, ml, mw;
        logic [4:0]  mrd;
        logic [31:0] mval;
        logic        cmp;
        logic [31:0] mdata;
        logic        wv, ww;
        logic [4:0]  wrd;
        logic [31:0] wval;
        logic [31:0] e_rs0;
        logic [2:0]  e_sel0;
        logic [31:0] e_rs1;
        logic [2:0]  e_sel1;
        logic        e_stall;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rs0;
        logic [2:0]  sel0;
        logic [31:0] rs1;
        logic [2:0]  sel1;
        logic        stall;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_cnt = '0;
    logic        last_stall = 1'b0;

    task automatic clear_inputs();
        bus.i_flush            = 1'b0;
        bus.i_ex_valid         = 1'b1;
        bus.i_ex_accept        = 1'b1;
        bus.i_rs_used          = 2'b11;
        bus.i_rs_addr_ex       = {5'd3, 5'd1};
        bus.i_rs_ex            = {RS1, RS0};
        bus.i_mem_valid        = 1'b0;
        bus.i_mem_is_load      = 1'b0;
        bus.i_rd_mem_wr_en     = 1'b0;
        bus.i_rd_addr_mem      = 5'd0;
        bus.i_rd_mem           = 32'h0;
        bus.i_mem_req_complete = 1'b0;
        bus.i_mem_data         = 32'h0;
        bus.i_wb_valid         = 1'b0;
        bus.i_rd_wb_wr_en      = 1'b0;
        bus.i_rd_addr_wb       = 5'd0;
        bus.i_rd_wb            = 32'h0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic cmp, input logic [31:0] data);
        bus.i_mem_valid        = 1'b1;
        bus.i_mem_is_load      = 1'b1;
        bus.i_rd_mem_wr_en     = 1'b1;
        bus.i_rd_addr_mem      = rd;
        bus.i_mem_req_complete = cmp;
        bus.i_mem_data         = data;
    endtask

    task automatic push(input string name, input logic [31:0] rs0, input logic [2:0] sel0,
                        input logic [31:0] rs1, input logic [2:0] sel1, input logic stall);
        exp_t e;
        e.name  = name;
        e.rs0   = rs0;
        e.sel0  = sel0;
        e.rs1   = rs1;
        e.sel1  = sel1;
        e.stall = stall;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        last_stall = stall;
    endtask

    task automatic chk(input string name, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, what, act, exp);
        end
    endtask

    task automatic check_now();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, "rs0",   bus.o_rs[31:0],                 e.rs0);
            chk(e.name, "sel0",  32'(bus.o_fwd_sel[2:0]),        32'(e.sel0));
            chk(e.name, "rs1",   bus.o_rs[63:32],                e.rs1);
            chk(e.name, "sel1",  32'(bus.o_fwd_sel[5:3]),        32'(e.sel1));
            chk(e.name, "stall", 32'(bus.o_load_stall),          32'(e.stall));
            chk(e.name, "cnt",   32'(bus.o_stall_count),         32'(e.cnt));
        end
    endtask

    // Compare this cycle, advance the counter model, then move to just after the next edge.
    task automatic check_cycle();
        #1;
        check_now();
        if (last_stall) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"mem_alu",     1'b1, 2'b11, 5'd5, 5'd3, 1'b1, 1'b0, 1'b1, 5'd5, 32'hAAAA_0001,
                     1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h0000_1234,
                     32'hAAAA_0001, 3'd1, RS1, 3'd0, 1'b0};
        vecs[1]  = '{"wb_only",     1'b1, 2'b11, 5'd5, 5'd3, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAAAA_0001,
                     1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h0000_1234,
                     32'h0000_1234, 3'd3, RS1, 3'd0, 1'b0};
        vecs[2]  = '{"zero_addr",   1'b1, 2'b11, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 32'h0000_FFFF,
                     1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 5'd0, 32'h0,
                     32'h0, 3'd5, RS1, 3'd0, 1'b0};
        vecs[3]  = '{"regfile",     1'b1, 2'b11, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h1,
                     1'b0, 32'h0, 1'b1, 1'b1, 5'd8, 32'h2,
                     RS0, 3'd0, 32'h0, 3'd5, 1'b0};
        vecs[4]  = '{"load_pend",   1'b1, 2'b11, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0,
                     1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0,
                     RS0, 3'd0, RS1, 3'd0, 1'b1};
        vecs[5]  = '{"pend_unused", 1'b1, 2'b10, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0,
                     1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0,
                     RS0, 3'd0, RS1, 3'd0, 1'b0};
        vecs[6]  = '{"pend_port1",  1'b1, 2'b11, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0,
                     1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0,
                     RS0, 3'd0, RS1, 3'd0, 1'b1};
        vecs[7]  = '{"load_done",   1'b1, 2'b11, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0,
                     1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0,
                     32'hDEAD_BEEF, 3'd2, RS1, 3'd0, 1'b0};
        vecs[8]  = '{"load_killed", 1'b1, 2'b11, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0,
                     1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0,
                     RS0, 3'd0, RS1, 3'd0, 1'b0};
        vecs[9]  = '{"mem_over_wb", 1'b1, 2'b11, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0011,
                     1'b0, 32'h0, 1'b1, 1'b1, 5'd9, 32'h0000_0022,
                     32'h0000_0011, 3'd1, 32'h0000_0011, 3'd1, 1'b0};
        vecs[10] = '{"wb_wren0",    1'b1, 2'b11, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0,
                     1'b0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0000_0022,
                     RS0, 3'd0, RS1, 3'd0, 1'b0};
        vecs[11] = '{"ex_invalid",  1'b0, 2'b11, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0,
                     1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                     RS0, 3'd0, RS1, 3'd0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        clear_inputs();
        #2;
        push("reset", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle forwarding vectors
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            bus.i_ex_valid         = vecs[i].ex_valid;
            bus.i_rs_used          = vecs[i].used;
            bus.i_rs_addr_ex       = {vecs[i].a1, vecs[i].a0};
            bus.i_mem_valid        = vecs[i].mv;
            bus.i_mem_is_load      = vecs[i].ml;
            bus.i_rd_mem_wr_en     = vecs[i].mw;
            bus.i_rd_addr_mem      = vecs[i].mrd;
            bus.i_rd_mem           = vecs[i].mval;
            bus.i_mem_req_complete = vecs[i].cmp;
            bus.i_mem_data         = vecs[i].mdata;
            bus.i_wb_valid         = vecs[i].wv;
            bus.i_rd_wb_wr_en      = vecs[i].ww;
            bus.i_rd_addr_wb       = vecs[i].wrd;
            bus.i_rd_wb            = vecs[i].wval;
            push(vecs[i].name, vecs[i].e_rs0, vecs[i].e_sel0, vecs[i].e_rs1, vecs[i].e_sel1,
                 vecs[i].e_stall);
            check_cycle();
        end

        // Synchronous-looking reset so the stall count starts from zero
        clear_inputs();
        rst_n = 1'b0;
        exp_cnt = '0;
        push("rst_sync", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();
        rst_n = 1'b1;

        // A: three stall cycles, then completion accepted in the same cycle
        clear_inputs();
        bus.i_rs_addr_ex = {5'd3, 5'd7};
        bus.i_ex_accept  = 1'b0;
        set_load(5'd7, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            push("A_stall", RS0, 3'd0, RS1, 3'd0, 1'b1);
            check_cycle();
        end
        set_load(5'd7, 1'b1, 32'hDEAD_BEEF);
        bus.i_ex_accept = 1'b1;
        push("A_done", 32'hDEAD_BEEF, 3'd2, RS1, 3'd0, 1'b0);
        check_cycle();
        bus.i_mem_valid = 1'b0;
        push("A_no_hold", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();

        // B: completion while EX is held, then a second load-use replaces the hold
        bus.i_ex_accept = 1'b0;
        set_load(5'd7, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            push("B_stall", RS0, 3'd0, RS1, 3'd0, 1'b1);
            check_cycle();
        end
        set_load(5'd7, 1'b1, 32'hDEAD_BEEF);
        push("B_done", 32'hDEAD_BEEF, 3'd2, RS1, 3'd0, 1'b0);
        check_cycle();
        bus.i_mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push("B_hold", 32'hDEAD_BEEF, 3'd4, RS1, 3'd0, 1'b0);
            check_cycle();
        end
        bus.i_rs_addr_ex = {5'd9, 5'd7};
        set_load(5'd9, 1'b0, 32'h0);
        push("B_hold_stall", 32'hDEAD_BEEF, 3'd4, RS1, 3'd0, 1'b1);
        check_cycle();
        set_load(5'd9, 1'b1, 32'h9999_0009);
        push("B_recap", 32'hDEAD_BEEF, 3'd4, 32'h9999_0009, 3'd2, 1'b0);
        check_cycle();
        bus.i_mem_valid = 1'b0;
        bus.i_ex_accept = 1'b1;
        push("B_replaced", RS0, 3'd0, 32'h9999_0009, 3'd4, 1'b0);
        check_cycle();
        push("B_cleared", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();

        // C: flush while holding
        clear_inputs();
        bus.i_rs_addr_ex = {5'd3, 5'd7};
        bus.i_ex_accept  = 1'b0;
        set_load(5'd7, 1'b1, 32'hCAFE_0007);
        push("C_capture", 32'hCAFE_0007, 3'd2, RS1, 3'd0, 1'b0);
        check_cycle();
        bus.i_mem_valid = 1'b0;
        bus.i_flush     = 1'b1;
        push("C_hold", 32'hCAFE_0007, 3'd4, RS1, 3'd0, 1'b0);
        check_cycle();
        bus.i_flush = 1'b0;
        push("C_flushed", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();

        // D: async reset while holding and stalled on another load
        set_load(5'd7, 1'b1, 32'hBEEF_0007);
        push("D_capture", 32'hBEEF_0007, 3'd2, RS1, 3'd0, 1'b0);
        check_cycle();
        bus.i_rs_addr_ex = {5'd9, 5'd7};
        set_load(5'd9, 1'b0, 32'h0);
        push("D_stall", 32'hBEEF_0007, 3'd4, RS1, 3'd0, 1'b1);
        check_cycle();
        #2;
        rst_n = 1'b0;
        exp_cnt = '0;
        push("D_async_rst", RS0, 3'd0, RS1, 3'd0, 1'b1);
        #1;
        check_now();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = 4'd1;
        clear_inputs();
        push("D_after", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();

        // E: counter saturation
        bus.i_rs_addr_ex = {5'd3, 5'd7};
        bus.i_ex_accept  = 1'b0;
        set_load(5'd7, 1'b0, 32'h0);
        for (int i = 0; i < 18; i++) begin
            push("E_sat", RS0, 3'd0, RS1, 3'd0, 1'b1);
            check_cycle();
        end
        clear_inputs();
        push("E_final", RS0, 3'd0, RS1, 3'd0, 1'b0);
        check_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
